i2s_out: RTL and testbench

//  I2S master transmitter; the output-direction counterpart of the I2S input path.

---
 rtl/i2s_pkg.sv | 9 +
 rtl/i2s_out_if.sv | 9 +
 rtl/i2so_serializer.sv | 101 ++++++++++
 rtl/i2s_out.sv | 55 +++++
 tb/tb_i2s_out.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S output path.
package i2s_pkg;
  localparam int I2S_CH_W        = 16;
  localparam int I2S_FRAME_SLOTS = 32;
  localparam int I2S_WORD_W      = 32;
  localparam int I2S_SLOT_W      = $clog2(I2S_FRAME_SLOTS);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
endpackage

// File: rtl/i2s_out_if.sv
// Upstream word handshake: a 32-bit stereo word qualified by rts/rtr.
interface i2s_out_if;
  logic [i2s_pkg::I2S_WORD_W-1:0] i2so_data;
  logic                           i2so_rts;
  logic                           i2so_rtr;

  modport master (output i2so_data, output i2so_rts, input i2so_rtr);
  modport slave  (input i2so_data, input i2so_rts, output i2so_rtr);
endinterface

// File: rtl/i2so_serializer.sv
// Bit-clock divider, 32-slot frame sequencer and Philips-format serializer.
// Requests a new word (ld_req) at every frame start.
module i2so_serializer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  ld_req,
  input  logic [I2S_WORD_W-1:0] ld_data,
  input  logic                  ld_valid,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                  state, state_nx;
  logic [DIV_W-1:0]        div, div_nx;
  logic [I2S_SLOT_W-1:0]   slot, slot_nx;
  logic [I2S_WORD_W-1:0]   shreg, shreg_nx;
  logic                    sck_nx, ws_nx, sd_nx;
  logic                    wrap, fall;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      div   <= '0;
      slot  <= '0;
      shreg <= '0;
      sck   <= 1'b0;
      ws    <= 1'b0;
      sd    <= 1'b0;
    end else begin
      state <= state_nx;
      div   <= div_nx;
      slot  <= slot_nx;
      shreg <= shreg_nx;
      sck   <= sck_nx;
      ws    <= ws_nx;
      sd    <= sd_nx;
    end
  end

  // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_nx = state;
    div_nx   = div;
    slot_nx  = slot;
    shreg_nx = shreg;
    sck_nx   = sck;
    ws_nx    = ws;
    sd_nx    = sd;
    ld_req   = 1'b0;
    wrap     = (div == DIV_W'(CLK_DIV - 1));
    fall     = wrap && sck;

    case (state)
      IDLE: begin
        div_nx = '0;
        sck_nx = 1'b0;
        ws_nx  = 1'b0;
        sd_nx  = 1'b0;
        // Enabling acts as a virtual sck fall: slot 0 starts on this edge.
        if (en) begin
          state_nx = RUN;
          slot_nx  = '0;
          ld_req   = 1'b1;
          shreg_nx = ld_valid ? ld_data : '0;
        end
      end
      default: begin
        div_nx = wrap ? '0 : div + DIV_W'(1);
        if (wrap) sck_nx = ~sck;
        if (fall) begin
          slot_nx = slot + I2S_SLOT_W'(1);
          if (!en && slot_nx == '0) begin
            // Stop at the frame boundary; the trailing right-channel LSB is dropped.
            state_nx = IDLE;
            ws_nx    = 1'b0;
            sd_nx    = 1'b0;
            shreg_nx = '0;
          end else begin
            state_nx = en ? RUN : STOP;
            ws_nx    = (slot_nx >= I2S_SLOT_W'(I2S_CH_W));
            sd_nx    = shreg[I2S_WORD_W-1];
            if (slot_nx == '0) begin
              ld_req   = 1'b1;
              shreg_nx = ld_valid ? ld_data : '0;
            end else begin
              shreg_nx = {shreg[I2S_WORD_W-2:0], 1'b0};
            end
          end
        end
      end
    endcase
  end
endmodule

// File: rtl/i2s_out.sv
// I2S master transmitter: one-word holding register behind an rts/rtr handshake,
// a sticky underrun flag, and the bit serializer.
module i2s_out
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_i2so_en,
  input  logic        rf_underrun_clr,
  i2s_out_if.slave    up,
  output logic        i2so_sck,
  output logic        i2so_ws,
  output logic        i2so_sd,
  output logic        ro_fifo_underrun
);
  logic [I2S_WORD_W-1:0] hold;
  logic                  rtr;
  logic                  take;
  logic                  ld_req;

  assign take         = up.i2so_rts && rtr;
  assign up.i2so_rtr  = rtr;

  // A word landing on the frame-start edge is kept for the next frame (no bypass).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rtr <= 1'b1;
    else if (take)   rtr <= 1'b0;
    else if (ld_req) rtr <= 1'b1;
  end

  // NOTE: the data register carries no reset; rtr alone says whether it holds a valid word.
  always_ff @(posedge clk) begin
    if (take) hold <= up.i2so_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ro_fifo_underrun <= 1'b0;
    else if (ld_req && rtr)    ro_fifo_underrun <= 1'b1;
    else if (rf_underrun_clr)  ro_fifo_underrun <= 1'b0;
  end

  i2so_serializer #(.CLK_DIV(CLK_DIV)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .en       (rf_i2so_en),
    .ld_req   (ld_req),
    .ld_data  (hold),
    .ld_valid (!rtr),
    .sck      (i2so_sck),
    .ws       (i2so_ws),
    .sd       (i2so_sd)
  );
endmodule

// File: tb/tb_i2s_out.sv
// Scoreboard bench for i2s_out: a driver logs accepted words, a monitor replays
// frames from those words using slot/phase arithmetic and compares every cycle.
module tb_i2s_out;
  localparam int D     = 2;
  localparam int SLOT  = 2 * D;
  localparam int FRAME = 32 * SLOT;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  logic en, clr;
  logic sck, ws, sd, und;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  acc_t acc_q[$];

  i2s_out_if bus ();

  i2s_out #(.CLK_DIV(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .rf_i2so_en       (en),
    .rf_underrun_clr  (clr),
    .up               (bus),
    .i2so_sck         (sck),
    .i2so_ws          (ws),
    .i2so_sd          (sd),
    .ro_fifo_underrun (und)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // All drivers below are entered and left at a clk falling edge.
  task automatic wait_until(input int t);
    while (cyc + 1 < t) @(negedge clk);
  endtask

  task automatic start_run(output int e);
    en = 1'b1;
    e  = cyc + 1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int waited = 0;
    bus.i2so_data = w;
    bus.i2so_rts  = 1'b1;
    while (bus.i2so_rtr !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (bus.i2so_rtr !== 1'b1) begin
      check("rtr_wait", bus.i2so_rtr, 1);
      bus.i2so_rts = 1'b0;
      return;
    end
    acc_q.push_back('{data: w, cyc: cyc + 1});
    @(negedge clk);
    bus.i2so_rts = 1'b0;
  endtask

  // Monitor: reference model of frames, slots and the holding/underrun rules.
  initial begin
    bit          running;
    bit          frame_start;
    bit          mute;
    bit          und_m;
    int          slot, phase;
    logic [31:0] word;
    logic        prev_lsb;
    running = 0; und_m = 0; slot = 0; phase = 0; word = '0; prev_lsb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        running = 0;
        und_m   = 0;
        word    = '0;
        acc_q.delete();
        check("rst_sck", sck, 0);
        check("rst_ws", ws, 0);
        check("rst_sd", sd, 0);
        check("rst_underrun", und, 0);
        check("rst_rtr", bus.i2so_rtr, 1);
        continue;
      end
      frame_start = 0;
      mute        = 0;
      if (!running) begin
        if (en) begin
          running = 1; slot = 0; phase = 0; prev_lsb = 1'b0; frame_start = 1;
        end
      end else begin
        phase++;
        if (phase == SLOT) begin
          phase = 0;
          slot++;
          if (slot == 32) begin
            slot = 0;
            if (en) begin
              prev_lsb    = word[0];
              frame_start = 1;
            end else begin
              running = 0;
            end
          end
        end
      end
      if (frame_start) begin
        if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
          word = acc_q.pop_front().data;
        end else begin
          word = '0;
          mute = 1;
        end
      end
      if (frame_start && mute) und_m = 1;
      else if (clr)            und_m = 0;

      if (running) begin
        check("sck", sck, (phase >= D));
        check("ws", ws, (slot >= 16));
        check("sd", sd, (slot == 0) ? prev_lsb : word[32 - slot]);
      end else begin
        check("idle_sck", sck, 0);
        check("idle_ws", ws, 0);
        check("idle_sd", sd, 0);
      end
      check("rtr", bus.i2so_rtr, (acc_q.size() == 0));
      check("underrun", und, und_m);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int e;
    int guard;
    en = 1'b0; clr = 1'b0; bus.i2so_rts = 1'b0; bus.i2so_data = '0; rst = 1'b1;
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Prefilled known word, then a muted frame, then stop.
    send_word(32'hA5F0_0F5A);
    repeat (3) @(negedge clk);
    start_run(e);
    wait_until(e + FRAME + 10); en = 1'b0;
    wait_until(e + 2 * FRAME + 10);
    pulse_clr();

    // No data: muted frames, clear, clear colliding with a new underrun.
    repeat (3) @(negedge clk);
    start_run(e);
    wait_until(e + 50);             pulse_clr();
    wait_until(e + FRAME);          pulse_clr();
    wait_until(e + FRAME + 12);     pulse_clr();
    wait_until(e + FRAME + 20);     en = 1'b0;
    wait_until(e + 2 * FRAME + 4);

    // Three random words with rts held high: one per frame, no underrun.
    fork
      for (int i = 0; i < 3; i++) send_word($urandom);
      begin repeat (2) @(negedge clk); start_run(e); end
    join
    wait_until(e + 2 * FRAME + 20); en = 1'b0;
    wait_until(e + 3 * FRAME + 4);

    // Random words with random gaps while running.
    start_run(e);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      send_word($urandom);
    end
    guard = 0;
    while (acc_q.size() != 0 && guard < 2000) begin @(negedge clk); guard++; end
    en = 1'b0;
    repeat (2 * FRAME + 4) @(negedge clk);

    // Disable at slot 5; then disable at slot 5 and re-enable at slot 20.
    start_run(e);
    wait_until(e + 5 * SLOT + 1);   en = 1'b0;
    wait_until(e + FRAME + 40);
    start_run(e);
    wait_until(e + 5 * SLOT + 1);   en = 1'b0;
    wait_until(e + 20 * SLOT + 1);  en = 1'b1;
    wait_until(e + FRAME + 30);     en = 1'b0;
    wait_until(e + 2 * FRAME + 4);

    // Transfer landing on the frame-start edge with the holding register empty.
    pulse_clr();
    start_run(e);
    wait_until(e + FRAME);
    send_word($urandom);
    wait_until(e + 2 * FRAME + 20); en = 1'b0;
    wait_until(e + 3 * FRAME + 4);

    // Asynchronous reset mid-frame with a word held.
    send_word($urandom);
    start_run(e);
    @(negedge clk);
    send_word($urandom);
    wait_until(e + 70);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_sck", sck, 0);
    check("async_rst_ws", ws, 0);
    check("async_rst_sd", sd, 0);
    check("async_rst_underrun", und, 0);
    check("async_rst_rtr", bus.i2so_rtr, 1);
    en = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery after reset.
    send_word($urandom);
    start_run(e);
    wait_until(e + FRAME + 10); en = 1'b0;
    wait_until(e + 2 * FRAME + 4);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
